// File: rtl/rr_arbiter4_pkg.sv
// Shared constants for the 4-way round-robin arbiter: FSM encoding, grant width
// and a one-hot helper used by both the arbiter and its bench-facing outputs.
package rr_arbiter4_pkg;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam int GRANT_W = 4;

  function automatic logic [GRANT_W-1:0] onehot(input logic [1:0] idx);
    return GRANT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin selector: finds the first pending index after ptr,
// searching ptr+1, ptr+2, ptr+3 and finally ptr itself.
module rr_pick4
  import rr_arbiter4_pkg::*;
(
  input  logic [GRANT_W-1:0] i_pending,
  input  logic [1:0]         i_ptr,
  output logic [1:0]         o_winner,
  output logic               o_found
);

  logic [1:0] w_idx;

  // Walk from the lowest priority slot upward so the nearest hit is written last.
  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    w_idx    = '0;
    for (int k = GRANT_W; k >= 1; k--) begin
      w_idx = i_ptr + 2'(k);
      if (i_pending[w_idx]) begin
        o_winner = w_idx;
        o_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with sticky request capture, ack handshake
// and a grant watchdog that withdraws an unacknowledged grant after TIMEOUT cycles.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [GRANT_W-1:0] req,
  input  logic               ack,
  output logic [GRANT_W-1:0] grant,
  output logic               grant_valid,
  output logic [GRANT_W-1:0] pending,
  output logic               timeout
);

  localparam int CNT_W = 4;

  logic [0:0]         r_state;
  logic [GRANT_W-1:0] r_grant;
  logic [GRANT_W-1:0] r_pending;
  logic [1:0]         r_ptr;
  logic [1:0]         r_win;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_timeout;

  logic [1:0]         w_winner;
  logic               w_found;
  logic               w_ack_hit;
  logic               w_expire;
  logic [GRANT_W-1:0] w_clr;

  rr_pick4 u_pick (
    .i_pending (r_pending),
    .i_ptr     (r_ptr),
    .o_winner  (w_winner),
    .o_found   (w_found)
  );

  assign w_ack_hit = (r_state == GRANT) && ack;
  assign w_expire  = (r_state == GRANT) && !ack && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_clr     = w_ack_hit ? onehot(r_win) : '0;

  // A request on the ack edge re-arms its own pending bit: set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_pending <= '0;
      r_ptr     <= 2'd3;
      r_win     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | req;
      r_timeout <= w_expire;
      if (r_state == IDLE) begin
        if (w_found) begin
          r_state <= GRANT;
          r_grant <= onehot(w_winner);
          r_win   <= w_winner;
          r_cnt   <= '0;
        end
      end else begin
        if (w_ack_hit || w_expire) begin
          r_state <= IDLE;
          r_grant <= '0;
          r_ptr   <= r_win;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign grant       = r_grant;
  assign grant_valid = (r_state == GRANT);
  assign pending     = r_pending;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed and randomized checks of rr_arbiter4 (TIMEOUT=3) against a
// cycle-level reference model built from the arbitration rules.
module tb_rr_arbiter4;

  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [3:0] grant;
  logic       grant_valid;
  logic [3:0] pending;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit m_pend [4];
  bit m_busy;
  int m_win;
  int m_ptr;
  int m_wait;
  bit m_to;

  rr_arbiter4 #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .ack         (ack),
    .grant       (grant),
    .grant_valid (grant_valid),
    .pending     (pending),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_pend_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [3:0] m_grant_vec();
    logic [3:0] v;
    v = '0;
    if (m_busy) v[m_win] = 1'b1;
    return v;
  endfunction

  task automatic model_edge(input logic [3:0] r, input logic a, input logic rs);
    bit found;
    int idx;
    if (rs) begin
      for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
      m_busy = 1'b0; m_win = 0; m_ptr = 3; m_wait = 0; m_to = 1'b0;
      return;
    end
    m_to = 1'b0;
    if (m_busy) begin
      if (a) begin
        m_pend[m_win] = 1'b0;
        m_ptr  = m_win;
        m_busy = 1'b0;
      end else if (m_wait == TO - 1) begin
        m_ptr  = m_win;
        m_busy = 1'b0;
        m_to   = 1'b1;
      end else begin
        m_wait = m_wait + 1;
      end
    end else begin
      found = 1'b0;
      for (int off = 1; off <= 4; off++) begin
        idx = (m_ptr + off) % 4;
        if (!found && m_pend[idx]) begin
          found  = 1'b1;
          m_win  = idx;
          m_busy = 1'b1;
          m_wait = 0;
        end
      end
    end
    for (int i = 0; i < 4; i++) if (r[i]) m_pend[i] = 1'b1;
  endtask

  task automatic step(input logic [3:0] r, input logic a, input logic rs);
    req = r; ack = a; rst = rs;
    @(posedge clk);
    model_edge(r, a, rs);
    #1;
    chk("grant", grant, m_grant_vec());
    chk("grant_valid", {3'b0, grant_valid}, {3'b0, m_busy});
    chk("pending", pending, m_pend_vec());
    chk("timeout", {3'b0, timeout}, {3'b0, m_to});
  endtask

  logic [3:0] seen [5];
  int         n_seen;
  logic       prev_gv;
  int         gv_cnt;
  logic [3:0] exp_seq [5];

  initial begin
    rst = 1'b1; req = '0; ack = 1'b0;
    m_busy = 1'b0; m_win = 0; m_ptr = 3; m_wait = 0; m_to = 1'b0;
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;

    // Reset state
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    chk("reset_grant", grant, 4'b0000);
    chk("reset_pending", pending, 4'b0000);

    // Single request with one-edge latency
    step(4'b0100, 1'b0, 1'b0);
    chk("single_no_gv_yet", {3'b0, grant_valid}, 4'b0000);
    step(4'b0000, 1'b0, 1'b0);
    chk("single_grant", grant, 4'b0100);
    chk("single_gv", {3'b0, grant_valid}, 4'b0001);
    step(4'b0000, 1'b1, 1'b0);
    chk("single_pending_clr", pending, 4'b0000);

    // Round-robin fairness with all requesters held
    step(4'b0000, 1'b0, 1'b1);
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    n_seen = 0; prev_gv = 1'b0;
    for (int s = 0; s < 10; s++) begin
      step(4'b1111, 1'b1, 1'b0);
      chk("rr_idle_gap", {3'b0, prev_gv & grant_valid}, 4'b0000);
      if (grant_valid && n_seen < 5) begin
        seen[n_seen] = grant;
        n_seen++;
      end
      prev_gv = grant_valid;
    end
    chk("rr_count", 4'(n_seen), 4'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_seq%0d", i), seen[i], exp_seq[i]);

    // Timeout withdrawal and reissue
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    gv_cnt = 0;
    for (int s = 0; s < 3; s++) begin
      step(4'b0000, 1'b0, 1'b0);
      if (grant_valid) gv_cnt++;
    end
    chk("to_gv_cycles", 4'(gv_cnt), 4'd3);
    step(4'b0000, 1'b0, 1'b0);
    chk("to_pulse", {3'b0, timeout}, 4'b0001);
    chk("to_idle", {3'b0, grant_valid}, 4'b0000);
    chk("to_pending_kept", pending, 4'b0010);
    step(4'b0000, 1'b0, 1'b0);
    chk("to_reissue", grant, 4'b0010);
    chk("to_pulse_single", {3'b0, timeout}, 4'b0000);
    step(4'b0000, 1'b1, 1'b0);

    // Simultaneous set and clear on the granted index
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("sc_grant", grant, 4'b1000);
    step(4'b1000, 1'b1, 1'b0);
    chk("sc_pending", pending, 4'b1000);
    step(4'b0000, 1'b0, 1'b0);
    chk("sc_regrant", grant, 4'b1000);
    step(4'b0000, 1'b1, 1'b0);

    // Reset in the middle of a grant, with req asserted during reset
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1010, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("mid_grant", grant, 4'b0010);
    chk("mid_pending", pending, 4'b1010);
    step(4'b1111, 1'b0, 1'b1);
    chk("mid_rst_grant", grant, 4'b0000);
    chk("mid_rst_pending", pending, 4'b0000);
    chk("mid_rst_gv", {3'b0, grant_valid}, 4'b0000);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("mid_first_grant", grant, 4'b0001);

    // Randomized traffic against the model
    for (int s = 0; s < 400; s++) begin
      step(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
